corelet_ctrl: RTL

- Controller end of the corelet req/ack protocol.
- Responds to the corelet's weight and activation requests by streaming words from an input SRAM read port onto the corelet's input bus.
- Drains ofifo results into an output psum SRAM.
- One instance per corelet; sequenced by a top-level start/done handshake.

---
 rtl/corelet_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/corelet_ctrl.sv
// Controller side of the corelet req/ack protocol: streams weights then activations from the input SRAM and drains ofifo results to psum SRAM.
// Reads are issued one per cycle; core_in trails ack by one cycle. Results are written in the same cycle that req[2] is seen.
module corelet_ctrl #(
  parameter int rows    = 8,
  parameter int cols    = 8,
  parameter int psum_bw = 16,
  parameter int inst_bw = 16,
  parameter int addr_bw = 11,
  parameter int w_len   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [addr_bw-1:0]         w_base,
  input  logic [addr_bw-1:0]         a_base,
  input  logic [addr_bw-1:0]         o_base,
  input  logic [addr_bw-1:0]         act_len,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [addr_bw-1:0]         mem_addr,
  input  logic [4*rows-1:0]          mem_rdata,
  output logic [inst_bw-1:0]         core_inst,
  input  logic [3:0]                 core_req,
  output logic [3:0]                 core_ack,
  output logic [4*rows-1:0]          core_in,
  input  logic [psum_bw*cols-1:0]    core_out,
  output logic                       psum_wr_en,
  output logic [addr_bw-1:0]         psum_addr,
  output logic [psum_bw*cols-1:0]    psum_wdata
);

  typedef enum logic [3:0] {
    IDLE, NEW, WAIT_W, W_STRM, GAP, WAIT_A, A_STRM, DRAIN, FIN
  } state_t;

  typedef struct packed {
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] a_base;
    logic [addr_bw-1:0] o_base;
    logic [addr_bw-1:0] act_len;
  } tile_cfg_t;

  localparam logic [addr_bw-1:0] w_last = addr_bw'(w_len - 1);
  localparam logic [addr_bw-1:0] one    = addr_bw'(1);

  state_t             state, state_nxt;
  tile_cfg_t          cfg;
  logic [addr_bw-1:0] k_cnt, k_nxt;
  logic [addr_bw-1:0] r_cnt;
  logic               ack_q;
  logic               cap_en;
  logic               wr_fire;
  logic               unused_req;

  assign unused_req = core_req[3];

  // Capture window spans A_STRM and DRAIN, closing as soon as every result is in.
  assign cap_en  = ((state == A_STRM) || (state == DRAIN)) && (r_cnt != cfg.act_len);
  assign wr_fire = cap_en && core_req[2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cfg   <= '0;
      k_cnt <= '0;
      r_cnt <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      k_cnt <= k_nxt;
      ack_q <= core_ack[0] | core_ack[1];
      if ((state == IDLE) && start) begin
        cfg   <= '{w_base: w_base, a_base: a_base, o_base: o_base, act_len: act_len};
        r_cnt <= '0;
      end else if (wr_fire) begin
        r_cnt <= r_cnt + one;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k_cnt;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    core_inst = '0;
    core_ack  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = NEW;
          k_nxt     = '0;
        end
      end
      NEW: begin
        busy         = 1'b1;
        core_inst[4] = 1'b1;
        state_nxt    = WAIT_W;
      end
      WAIT_W: begin
        busy = 1'b1;
        if (core_req[0]) begin
          state_nxt = W_STRM;
          k_nxt     = '0;
        end
      end
      W_STRM: begin
        busy        = 1'b1;
        core_ack[0] = 1'b1;
        mem_rd_en   = 1'b1;
        mem_addr    = cfg.w_base + k_cnt;
        if (k_cnt == w_last) begin
          state_nxt = GAP;
          k_nxt     = '0;
        end else begin
          k_nxt = k_cnt + one;
        end
      end
      // Two dead cycles so the corelet sees ack[0] fall before ack[1] rises.
      GAP: begin
        busy = 1'b1;
        if (k_cnt == one) begin
          state_nxt = WAIT_A;
          k_nxt     = '0;
        end else begin
          k_nxt = k_cnt + one;
        end
      end
      WAIT_A: begin
        busy = 1'b1;
        if (cfg.act_len == '0) begin
          state_nxt = FIN;
        end else if (core_req[1]) begin
          state_nxt = A_STRM;
          k_nxt     = '0;
        end
      end
      A_STRM: begin
        busy        = 1'b1;
        core_ack[1] = 1'b1;
        mem_rd_en   = 1'b1;
        mem_addr    = cfg.a_base + k_cnt;
        if (k_cnt == cfg.act_len - one) begin
          state_nxt = DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k_cnt + one;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_cnt == cfg.act_len) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign core_in    = ack_q ? mem_rdata : '0;
  assign psum_wr_en = wr_fire;
  assign psum_addr  = wr_fire ? cfg.o_base + r_cnt : '0;
  assign psum_wdata = wr_fire ? core_out : '0;

endmodule
